// File: rtl/exp_fifo_drain_acc.sv
// Drains batch_len words from the result FIFO and sums them into acc_out.
// Optional empty-wait timeout is enabled by defining EXP_DRAIN_TIMEOUT_EN.
module exp_fifo_drain_acc #(
  parameter int DATA_W      = 21,
  parameter int LEN_W       = 4,
  parameter int ACC_W       = 25,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  batch_len,
  input  logic              empty,
  input  logic [DATA_W-1:0] q,
  output logic              rd_req,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, CAP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, count_reg, count_inc;
  logic [ACC_W-1:0]   acc_reg;
  logic               timeout_hit;
  logic               accept;

  assign accept    = (state_reg == IDLE) && start;
  assign count_inc = count_reg + 1'b1;

`ifdef EXP_DRAIN_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_reg;
  logic              err_reg;

  // Fires on the TIMEOUT_CYC-th consecutive empty cycle spent in REQ.
  assign timeout_hit = (state_reg == REQ) && empty &&
                       (wait_reg == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_reg <= '0;
      err_reg  <= 1'b0;
    end else if (accept) begin
      wait_reg <= '0;
      err_reg  <= 1'b0;
    end else if (state_reg == REQ) begin
      if (!empty) begin
        wait_reg <= '0;
      end else if (timeout_hit) begin
        wait_reg <= '0;
        err_reg  <= 1'b1;
      end else begin
        wait_reg <= wait_reg + 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    rd_req     = 1'b0;
    acc_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (batch_len == '0) ? DONE : REQ;
      end
      REQ: begin
        if (timeout_hit) begin
          state_next = DONE;
        end else if (!empty) begin
          rd_req     = 1'b1;
          state_next = CAP;
        end
      end
      CAP: begin
        state_next = (count_inc == len_reg) ? DONE : REQ;
      end
      DONE: begin
        acc_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        len_reg   <= batch_len;
        count_reg <= '0;
        acc_reg   <= '0;
      end else if (state_reg == CAP) begin
        // q belongs to the read issued in the preceding REQ cycle.
        acc_reg   <= acc_reg + ACC_W'(q);
        count_reg <= count_inc;
      end
    end
  end

  assign acc_out = acc_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_exp_fifo_drain_acc.sv
// Randomized bench for exp_fifo_drain_acc with a queue-based FIFO and sum model.
// Timeout scenario runs only when EXP_DRAIN_TIMEOUT_EN is defined.
module tb_exp_fifo_drain_acc;
  localparam int DATA_W = 21;
  localparam int LEN_W  = 4;
  localparam int ACC_W  = 25;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  batch_len = '0;
  logic              empty = 1'b1;
  logic [DATA_W-1:0] q = '0;
  logic              rd_req, acc_valid, busy, err;
  logic [ACC_W-1:0]  acc_out;

  int total = 0;
  int bad   = 0;

  exp_fifo_drain_acc #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .batch_len(batch_len), .empty(empty), .q(q),
    .rd_req(rd_req), .acc_out(acc_out), .acc_valid(acc_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: words become visible at scheduled cycles, q updates the edge after rd_req.
  logic [DATA_W-1:0] fq[$];
  int                sched_at[$];
  logic [DATA_W-1:0] sched_d[$];
  logic [DATA_W-1:0] wq[$];
  int                cyc = 0;
  bit                flush = 0;

  always @(posedge clk) begin
    cyc++;
    if (rd_req && fq.size() > 0) q <= fq.pop_front();
    if (flush) begin
      fq.delete();
      sched_at.delete();
      sched_d.delete();
      flush = 0;
    end
    while (sched_at.size() > 0 && sched_at[0] <= cyc) begin
      fq.push_back(sched_d[0]);
      void'(sched_at.pop_front());
      void'(sched_d.pop_front());
    end
    empty <= (fq.size() == 0);
  end

  task automatic push_word(input logic [DATA_W-1:0] d, input int delay);
    sched_at.push_back(cyc + delay);
    sched_d.push_back(d);
  endtask

  // One batch: first n_pre words preloaded, the rest arrive gap cycles apart.
  // A second start is pulsed at cycle poke (0 = none) and must be ignored.
  task automatic run_batch(input string name, input int len, input int n_pre, input int gap, input int poke);
    logic [ACC_W-1:0] exp_sum;
    int reads, lat, viol, busy_low, bad_pos;
    bit seen;
    exp_sum = '0; reads = 0; viol = 0; busy_low = 0; bad_pos = 0; seen = 0; lat = 0;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      exp_sum += ACC_W'(wq[i]);
      push_word(wq[i], (i < n_pre) ? 0 : gap * (i - n_pre + 1));
    end
    @(negedge clk);
    start = 1'b1;
    batch_len = LEN_W'(len);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      lat = c;
      start = (c == poke);
      if (c == poke) batch_len = LEN_W'(7);
      if (rd_req) begin
        reads++;
        if (empty) viol++;
        if ((c % 2) == 0) bad_pos++;
      end
      if (!busy) busy_low++;
      if (acc_valid) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    check({name, "_valid_seen"}, 64'(seen), 64'd1);
    check({name, "_acc"}, 64'(acc_out), 64'(exp_sum));
    check({name, "_reads"}, 64'(reads), 64'(len));
    check({name, "_no_rd_on_empty"}, 64'(viol), 64'd0);
    check({name, "_busy_held"}, 64'(busy_low), 64'd0);
    check({name, "_err"}, 64'(err), 64'd0);
    if (n_pre >= len) begin
      check({name, "_latency"}, 64'(lat), 64'(2 * len + 1));
      check({name, "_rd_cycles"}, 64'(bad_pos), 64'd0);
    end
    @(negedge clk);
    check({name, "_pulse_one"}, 64'(acc_valid), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_hold"}, 64'(acc_out), 64'(exp_sum));
    $display("batch %s len=%0d pre=%0d gap=%0d sum=%0h lat=%0d", name, len, n_pre, gap, exp_sum, lat);
  endtask

  initial begin
    int len;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_acc", 64'(acc_out), 64'd0);
    check("rst_valid", 64'(acc_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset during the second capture discards the partial sum
    for (int i = 0; i < 3; i++) push_word(DATA_W'(i + 1), 0);
    @(negedge clk);
    start = 1'b1; batch_len = 3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0; flush = 1;
    @(negedge clk);
    check("mid_rd_req", 64'(rd_req), 64'd0);
    check("mid_busy_cleared", 64'(busy), 64'd0);
    check("mid_acc", 64'(acc_out), 64'd0);
    check("mid_valid", 64'(acc_valid), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_stays_idle", 64'({busy, rd_req, acc_valid}), 64'd0);
    $display("batch reset_mid len=3 discarded");

    // Basic batch
    wq.delete();
    wq.push_back(21'h000100); wq.push_back(21'h000200);
    wq.push_back(21'h000300); wq.push_back(21'h000400);
    run_batch("basic", 4, 4, 1, 0);
    check("basic_sum_const", 64'(acc_out), 64'h0A00);

    // Stall on empty
    wq.delete();
    wq.push_back(21'h1FFFFF); wq.push_back(21'h1FFFFF);
    run_batch("stall", 2, 1, 10, 0);
    check("stall_sum_const", 64'(acc_out), 64'h3FFFFE);

    // Zero length, then start while busy
    wq.delete();
    run_batch("zero", 0, 0, 1, 0);
    check("zero_sum_const", 64'(acc_out), 64'd0);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(DATA_W'($urandom));
    run_batch("restart_ignored", 4, 4, 1, 3);

    // Maximum batch, all ones
    wq.delete();
    for (int i = 0; i < 15; i++) wq.push_back(21'h1FFFFF);
    run_batch("max", 15, 15, 1, 0);
    check("max_sum_const", 64'(acc_out), 64'h1DFFFF1);

    // Randomized batches
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(0, 15);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(DATA_W'($urandom));
      run_batch($sformatf("rand%0d", t), len, $urandom_range(0, len), $urandom_range(1, 8),
                (len > 1) ? $urandom_range(0, 2 * len - 1) : 0);
    end

`ifdef EXP_DRAIN_TIMEOUT_EN
    begin
      bit seen;
      int lat;
      seen = 0; lat = 0;
      push_word(21'h012345, 0);
      @(negedge clk);
      start = 1'b1; batch_len = 3;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        start = 1'b0;
        lat = c;
        if (acc_valid) begin
          seen = 1;
          break;
        end
      end
      check("to_valid_seen", 64'(seen), 64'd1);
      check("to_err", 64'(err), 64'd1);
      check("to_acc", 64'(acc_out), 64'h012345);
      check("to_latency", 64'(lat), 64'd67);
      @(negedge clk);
      check("to_err_sticky", 64'(err), 64'd1);
      start = 1'b1; batch_len = 0;
      @(negedge clk);
      start = 1'b0;
      check("to_err_cleared", 64'(err), 64'd0);
      $display("batch timeout len=3 sum=12345 lat=%0d", lat);
      @(negedge clk);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exp_fifo_drain_acc.md
Name: exp_fifo_drain_acc

Overview:
Downstream consumer of the exponential/accumulate wrapper's result FIFO.
- Drains a software-specified number of 21-bit results (q) from the FIFO with a one-at-a-time rd_req handshake.
- Sums them into a wide accumulator and presents the final sum with a one-cycle valid pulse.
- Sits between the FIFO output (q/empty) and the system result register / top-level controller.

Parameters:
DATA_W, 21, width of a FIFO word ({x_int, x_frac} shifted by ui).
LEN_W, 4, width of batch length input; max batch 2^LEN_W-1 = 15.
ACC_W, 25, accumulator width = DATA_W + LEN_W; cannot overflow for any legal batch.
TIMEOUT_CYC, 64, empty-wait limit in cycles (used only with optional feature).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset; sampled on rising clk.
start  in  1  one-cycle pulse: begin a batch; ignored unless idle.
batch_len  in  LEN_W  number of FIFO words to consume; sampled with start.
empty  in  1  FIFO empty flag.
q  in  DATA_W  FIFO read data; valid the cycle after rd_req.
rd_req  out  1  FIFO read request, single-cycle pulse.
acc_out  out  ACC_W  accumulated sum; holds its value until the next start.
acc_valid  out  1  one-cycle pulse when acc_out is final.
busy  out  1  high from the cycle after start until acc_valid.
err  out  1  timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, rd_req=0, acc_out=0, acc_valid=0, busy=0, err=0, count=0. Reset overrides any in-progress batch; a partial sum is discarded.
- State machine states: IDLE, REQ, CAP, DONE.
- IDLE:
  - start=1 latches batch_len into len_r, clears acc_out, clears count, and clears err.
  - If batch_len=0, go to DONE (acc_out=0). Otherwise go to REQ.
- REQ:
  - If empty=0, drive rd_req=1 for exactly this cycle and go to CAP.
  - If empty=1, rd_req=0 and stay in REQ.
- CAP:
  - acc_out <= acc_out + zero-extended q; count <= count+1.
  - If count+1 == len_r, go to DONE; else go to REQ.
- DONE: acc_valid=1 for this cycle only, then go to IDLE.
- busy = (state != IDLE).
- Throughput: 2 cycles per word when the FIFO is non-empty. Latency from start to acc_valid = 2*len+1 cycles with no stalls.
- rd_req is never asserted while empty=1. At most one read is outstanding. rd_req and CAP never overlap.
- start while busy is ignored: no latch, no restart.
- Arithmetic is unsigned, with no saturation needed (ACC_W sized for the worst case 15*(2^21-1)).
- empty rising between rd_req and CAP does not affect the capture; data was already requested.

Optional Feature:
Macro: EXP_DRAIN_TIMEOUT_EN
- Defined:
  - A wait counter increments each cycle in REQ with empty=1, and clears on any read.
  - When it reaches TIMEOUT_CYC, set err=1 and go to DONE. acc_valid pulses with the partial sum.
  - err stays high until the next accepted start or reset.
- Undefined: REQ waits indefinitely; no counter logic exists; err is tied to 0.

Test Plan:
- Reset mid-batch: start len=3, drop rst during the second CAP -> next cycle rd_req=0, busy=0, acc_out=0, no acc_valid.
- Basic batch: FIFO preloaded with 21'h000100, 21'h000200, 21'h000300, 21'h000400; start len=4 -> exactly 4 rd_req pulses at cycles 1,3,5,7; acc_valid at cycle 9; acc_out=25'h000A00.
- Stall on empty: FIFO holds 1 word (21'h1FFFFF); start len=2; second word pushed 10 cycles later -> rd_req stays 0 while empty=1; acc_out=25'h3FFFFE after final acc_valid.
- Zero length / start while busy: start len=0 -> acc_valid next-next cycle, acc_out=0, no rd_req. Pulse start during a len=4 batch -> ignored, still exactly 4 reads.
- Max batch overflow check: 15 words of 21'h1FFFFF -> acc_out=25'h1DFFFF1, no wrap.
- EXP_DRAIN_TIMEOUT_EN defined, TIMEOUT_CYC=64: start len=3 with only 1 word available -> after 64 empty cycles, err=1, acc_valid pulses, acc_out = that word. Next start clears err.
